// File: rtl/mac_vector_unit.sv
// Multi-lane signed fixed-point dot-product MAC with a two-stage pipeline and rounded result.
// Define MAC_SATURATE_EN to clip out-of-range results and flag them on out_sat_o.
module mac_vector_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned GUARD_BITS = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic                        in_last_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_sat_o,
  output logic [15:0]                 beat_count_o
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  localparam int unsigned AccWidth  = ProdWidth + GUARD_BITS;
  localparam logic signed [AccWidth-1:0] RoundInc = AccWidth'(1) << (FRAC_BITS - 1);
`ifdef MAC_SATURATE_EN
  localparam logic signed [AccWidth-1:0] SatMax =
      {{(AccWidth - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AccWidth-1:0] SatMin =
      {{(AccWidth - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e                       state_q, state_d;
  logic                         drain_q, drain_d;
  logic signed [AccWidth-1:0]   sum_q, sum_d;
  logic signed [AccWidth-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic                         sat_q, sat_d;
  logic [15:0]                  cnt_q, cnt_d;

  logic signed [DATA_WIDTH-1:0] a_lane, b_lane;
  logic signed [ProdWidth-1:0]  prod;
  logic signed [AccWidth-1:0]   lane_sum;
  logic signed [AccWidth-1:0]   rounded, shifted;
  logic [DATA_WIDTH-1:0]        res;
  logic                         res_sat;
  logic                         accept;

  always_comb begin
    lane_sum = '0;
    a_lane   = '0;
    b_lane   = '0;
    prod     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_lane   = a_i[i*DATA_WIDTH +: DATA_WIDTH];
      b_lane   = b_i[i*DATA_WIDTH +: DATA_WIDTH];
      prod     = ProdWidth'(a_lane) * ProdWidth'(b_lane);
      lane_sum = lane_sum + $signed({{GUARD_BITS{prod[ProdWidth-1]}}, prod});
    end
  end

  // Round half up, then arithmetic shift back to the operand scaling.
  always_comb begin
    rounded = acc_q + RoundInc;
    shifted = rounded >>> FRAC_BITS;
`ifdef MAC_SATURATE_EN
    if (shifted > SatMax) begin
      res     = DATA_WIDTH'(SatMax);
      res_sat = 1'b1;
    end else if (shifted < SatMin) begin
      res     = DATA_WIDTH'(SatMin);
      res_sat = 1'b1;
    end else begin
      res     = DATA_WIDTH'(shifted);
      res_sat = 1'b0;
    end
`else
    res     = DATA_WIDTH'(shifted);
    res_sat = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    sum_d       = '0;
    acc_d       = acc_q + sum_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    sat_d       = sat_q;
    in_ready_o  = (state_q == StIdle) || (state_q == StAccum);
    out_valid_o = (state_q == StDone);
    accept      = in_valid_i && in_ready_o;

    if (clear_i) begin
      state_d = StIdle;
      drain_d = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        sum_d = lane_sum;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) state_d = in_last_i ? StDrain : StAccum;
        end
        // First DRAIN cycle lets the last stage-2 add land; the second registers the result.
        StDrain: begin
          if (!drain_q) begin
            drain_d = 1'b1;
          end else begin
            drain_d = 1'b0;
            state_d = StDone;
            data_d  = res;
            sat_d   = res_sat;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      drain_q <= 1'b0;
      sum_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data_o   = data_q;
  assign out_sat_o    = sat_q;
  assign beat_count_o = cnt_q;

endmodule

// File: tb/tb_mac_vector_unit.sv
// Self-checking bench for mac_vector_unit: transaction-level dot-product model plus
// directed vectors with hand-computed results.
module tb_mac_vector_unit;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int LN = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [LN*DW-1:0] a, b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sat;
  logic [15:0]     beat_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_vector_unit #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB),
    .LANES     (LN),
    .GUARD_BITS(8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_sat_o   (out_sat),
    .beat_count_o(beat_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 collecting beats, 1 waiting out the latency, 2 result held.
  int          m_phase;
  longint      m_sum;
  int          m_cnt;
  int          m_lat;
  logic [15:0] m_data;
  logic        m_sat;

  function automatic longint dot(input logic [LN*DW-1:0] av, input logic [LN*DW-1:0] bv);
    longint s = 0;
    logic signed [DW-1:0] x, y;
    for (int i = 0; i < LN; i++) begin
      x = av[i*DW +: DW];
      y = bv[i*DW +: DW];
      s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_sum = 0; m_cnt = 0; m_lat = 0; m_data = '0; m_sat = 1'b0;
    end else if (clear) begin
      m_phase = 0; m_sum = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          longint r;
          m_sum += dot(a, b);
          if (m_cnt < 65535) m_cnt++;
          if (in_last) begin
            r = (m_sum + (longint'(1) << (FB - 1))) >>> FB;
`ifdef MAC_SATURATE_EN
            if (r > 32767) begin
              m_data = 16'h7FFF; m_sat = 1'b1;
            end else if (r < -32768) begin
              m_data = 16'h8000; m_sat = 1'b1;
            end else begin
              m_data = 16'(r); m_sat = 1'b0;
            end
`else
            m_data = 16'(r);
            m_sat  = 1'b0;
`endif
            m_phase = 1;
            m_lat   = 1;
          end
        end
        1: if (m_lat == 0) m_phase = 2; else m_lat--;
        default: if (out_ready) begin
          m_phase = 0; m_sum = 0; m_cnt = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_phase == 0);
    check("out_valid", out_valid, m_phase == 2);
    check("beat_count", beat_count, m_cnt);
    if (m_phase == 2) begin
      check("model_data", out_data, m_data);
      check("model_sat", out_sat, m_sat);
    end
  end

  task automatic beat(input logic [15:0] av, input logic [15:0] bv, input logic last);
    in_valid = 1'b1;
    a        = {LN{av}};
    b        = {LN{bv}};
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [15:0] exp_d, input logic exp_s,
                            input int exp_cnt, input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_valid"}, out_valid, 1);
    if (exp_lat > 0) check({name, "_latency"}, n, exp_lat);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_sat"}, out_sat, exp_s);
    check({name, "_count"}, beat_count, exp_cnt);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4 x (1.0 * 2.0) = 8.0
    beat(16'h0100, 16'h0200, 1'b1);
    get_result("single", 16'h0800, 1'b0, 1, 3);

    // 12 x (1.5 * -1.0) = -18.0
    beat(16'h0180, 16'hFF00, 1'b0);
    beat(16'h0180, 16'hFF00, 1'b0);
    beat(16'h0180, 16'hFF00, 1'b1);
    get_result("neg3", 16'hEE00, 1'b0, 3, 3);

    // 32 x 127^2 overflows the Q8.8 range
    repeat (7) beat(16'h7F00, 16'h7F00, 1'b0);
    beat(16'h7F00, 16'h7F00, 1'b1);
`ifdef MAC_SATURATE_EN
    get_result("ovf", 16'h7FFF, 1'b1, 8, 3);
`else
    get_result("ovf", 16'h2000, 1'b0, 8, 3);
`endif

    // Back-pressure: result must hold while beats are offered and ignored
    beat(16'h0100, 16'h0100, 1'b1);
    in_valid = 1'b1;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", out_data, 16'h0400);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    get_result("hold", 16'h0400, 1'b0, 1, -1);
    check("hold_idle_ready", in_ready, 1);
    check("hold_idle_count", beat_count, 0);

    // Clear with a simultaneous beat discards both the partial sum and that beat
    beat(16'h0100, 16'h0100, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    a        = {LN{16'h0300}};
    b        = {LN{16'h0300}};
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_count", beat_count, 0);
    beat(16'h0100, 16'h0100, 1'b1);
    get_result("clear", 16'h0400, 1'b0, 1, 3);

    // Asynchronous reset mid-accumulation
    beat(16'h0180, 16'hFF00, 1'b0);
    beat(16'h0180, 16'hFF00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_sat", out_sat, 0);
    check("arst_beat_count", beat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(16'h0100, 16'h0200, 1'b1);
    get_result("after_rst", 16'h0800, 1'b0, 1, 3);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_vector_unit.md
MAC_VECTOR_UNIT -- requirements
Module: mac_vector_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each signed fixed-point operand and of the result.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of operands and result (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 Parameter LANES, default 4: parallel multiplier lanes per input beat.
REQ-004 Parameter GUARD_BITS, default 8: accumulator headroom; ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS.
REQ-005 clk  input  1  single clock, all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous abort: discards the partial sum and pipeline contents, returns to IDLE.
REQ-008 in_valid  input  1  beat present on a/b/in_last.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
REQ-010 a  input  LANES*DATA_WIDTH  packed signed operands; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 b  input  LANES*DATA_WIDTH  packed signed operands, same packing.
REQ-012 in_last  input  1  marks final beat of a dot product.
REQ-013 out_valid  output  1  result held valid.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 out_data  output  DATA_WIDTH  signed result.
REQ-016 out_sat  output  1  result was clipped (always 0 without MAC_SATURATE_EN).
REQ-017 beat_count  output  16  beats accepted in current dot product, saturating at 0xFFFF.

Function
REQ-018 Per beat, each lane forms the full 2*DATA_WIDTH signed product; lanes summed sign-extended to ACC_WIDTH.
REQ-019 Pipeline: stage 1 registers the lane sum at the accepting edge; stage 2 adds it to the accumulator at the next edge.
REQ-020 States: IDLE, ACCUM, DRAIN, DONE.
REQ-021 IDLE: accumulator 0, in_ready=1; accepted beat without in_last -> ACCUM; with in_last -> DRAIN.
REQ-022 ACCUM: in_ready=1; accepted beat with in_last -> DRAIN; beats back-to-back every cycle without bubbles.
REQ-023 DRAIN: in_ready=0; final stage-2 add completes, result formed and registered -> DONE.
REQ-024 Result = accumulator arithmetically shifted right by FRAC_BITS, round-half-up (add 2^(FRAC_BITS-1) before shift).
REQ-025 out_valid rises at the second rising edge after the edge accepting the in_last beat (latency 2).
REQ-026 DONE: out_valid=1, in_ready=0, out_data/out_sat stable until handshake; on handshake -> IDLE, accumulator and beat_count cleared same edge.
REQ-027 beat_count increments on each accepted beat; reads the final count while in DONE.
REQ-028 clear has priority over every handshake in the same cycle; accepted beat in that cycle is discarded.
REQ-029 in_valid low in ACCUM leaves accumulator unchanged (stage 1 carries zero).

Reset
REQ-030 reset low asynchronously forces IDLE, accumulator 0, pipeline 0, out_valid=0, out_data=0, out_sat=0, beat_count=0; in_ready=1 after reset release.
REQ-031 Reset mid-operation discards all partial results; no out_valid is produced for the interrupted dot product.

Configuration
REQ-032 Macro MAC_SATURATE_EN defined: rounded result outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] clips to the nearest bound and sets out_sat=1.
REQ-033 MAC_SATURATE_EN undefined: result is the low DATA_WIDTH bits of the rounded value (two's-complement wrap), out_sat tied 0.

Verification (DATA_WIDTH=16, FRAC_BITS=8, LANES=4)
REQ-034 One beat, all a=0x0100, b=0x0200, in_last=1 -> out_data=0x0800 two edges later, beat_count=1, out_sat=0.
REQ-035 Three back-to-back beats of lanes a=0x0180, b=0xFF00 (1.5 x -1.0), last on third -> out_data=0xEE00 (-18.0), beat_count=3.
REQ-036 Eight beats all lanes 0x7F00 x 0x7F00 -> with MAC_SATURATE_EN out_data=0x7FFF, out_sat=1; without, wrapped low 16 bits.
REQ-037 out_ready held low 5 cycles in DONE -> out_data stable, in_ready=0; in_valid beats ignored; handshake returns IDLE.
REQ-038 clear asserted with an accepted beat in ACCUM, then one beat 0x0100 x 0x0100 last -> out_data=0x0400 (no stale sum).
REQ-039 reset pulsed low mid-ACCUM -> all outputs 0 immediately, no out_valid; next dot product correct from zero.
